hwpe_stream_burst_scheduler: RTL and testbench
==============================================

// Module: hwpe_stream_burst_scheduler
// PURPOSE
//  Shares one HWPE stream sink among NB_IN stream sources, granting whole bursts round-robin.
//  Sits in front of a single consumer, e.g. a streamer/FIFO, fed by several reservoirs or engines.
//  Ownership is held for burst_len_i beats, so packets from different sources never interleave.
// PARAMETERS
//  NB_IN       4   number of input streams (>=2)
//  DATA_WIDTH  32  stream data width (multiple of 8); strb width DATA_WIDTH/8
//  MAX_BURST   16  largest accepted burst length
//  BURST_W     $clog2(MAX_BURST+1)  width of burst_len_i (derived, do not override)
// PORTS
//  clk_i           in   1                   clock, rising edge
//  rst_ni          in   1                   reset, asynchronous, active-low
//  clear_i         in   1                   synchronous soft clear
//  enable_i        in   1                   allow new grants
//  req_mask_i      in   NB_IN               per-input eligibility mask
//  burst_len_i     in   BURST_W             beats per grant, sampled at grant
//  push_i          sink NB_IN x hwpe_stream_intf_stream(DATA_WIDTH)  input streams
//  pop_o           src  hwpe_stream_intf_stream(DATA_WIDTH)          shared output stream
//  grant_o         out  NB_IN               one-hot current owner, 0 when idle
//  busy_o          out  1                   burst in progress
//  burst_done_o    out  1                   1-cycle pulse on last beat of a burst
//  beat_cnt_o      out  NB_IN x 32          per-input accepted beats (optional feature)
// BEHAVIOUR
//  Reset/clear: state IDLE, owner=0, last_owner=NB_IN-1 (input 0 first), beat cnt=0, len=0.
//   Outputs at reset: pop_o.valid=0, data=0, strb=0; all push_i[k].ready=0; grant_o=0; busy_o=0; burst_done_o=0.
//  FSM IDLE -> BURST: enable_i & any(push_i[k].valid & req_mask_i[k]).
//   Winner is the first eligible k scanning last_owner+1 .. last_owner+NB_IN, mod NB_IN.
//   Registered: owner, last_owner<=winner, len<=max(burst_len_i,1) clipped to MAX_BURST, cnt<=0.
//   One bubble cycle between grant decision and first transferable beat.
//  BURST: pop_o.{valid,data,strb} = push_i[owner]; push_i[owner].ready = pop_o.ready.
//   Non-owners: ready=0. Zero-latency combinational pass-through; no storage.
//   Beat = pop_o.valid & pop_o.ready; cnt increments per beat.
//   Beat with cnt==len-1: burst_done_o=1 combinationally that cycle; next state IDLE.
//  IDLE: pop_o.valid=0, data/strb driven 0, all ready=0. Back-to-back grants cost one IDLE cycle.
//  Owner valid low mid-burst: stay in BURST and wait; no timeout, no preemption.
//  enable_i or req_mask_i[owner] dropping mid-burst: the burst still completes; they gate only new grants.
//  burst_len_i changes mid-burst: ignored until the next grant.
//  clear_i: takes priority over every transition; next cycle same as reset. An in-flight beat on the same cycle is still transferred.
//  Async reset mid-burst: immediate return to the reset state; the partially sent burst is abandoned.
// CONFIGURATION
//  HWPE_STREAM_BURST_SCHEDULER_PERF_EN
//   Defined: beat_cnt_o[k] counts beats accepted from input k.
//    Saturates at 32'hFFFF_FFFF; cleared by rst_ni/clear_i.
//   Undefined: beat_cnt_o tied to '0; no counter flops; all other behaviour identical.
// STRUCTURE
//  hwpe_stream_package: add typedef enum logic {BSCHED_IDLE, BSCHED_BURST} bsched_state_t.
//  Sub-module hwpe_stream_rr_pick (combinational): inputs req[NB_IN], last[$clog2(NB_IN)];
//   outputs one-hot gnt and index.
//  Top holds FSM, owner/len/cnt registers, output mux, optional counters.
// TESTING
//  1. Reset mid-burst, then release: all outputs 0 as listed; first grant to input 0 when all inputs valid.
//  2. NB_IN=4, all valid, len=4, pop ready=1 -> grants 0,1,2,3,0; 4 beats each; done pulse on beat 4; 1 idle cycle between.
//  3. Only input 2 valid, mask=4'b1111, len=3 -> repeated grants to 2; beat_cnt_o[2]=9 after 3 bursts (PERF_EN).
//  4. Owner stalls valid for 5 cycles mid-burst, pop ready toggling 50%
//     -> no non-owner ready, no data loss/duplication, byte-exact order.
//  5. burst_len_i=0 -> 1-beat bursts; burst_len_i=MAX_BURST+5 -> clipped to MAX_BURST beats.
//  6. clear_i asserted at beat 2 of 4 -> IDLE next cycle, last_owner reset, next grant to lowest eligible index.

Source files
------------

// File: rtl/hwpe_stream_burst_scheduler_pkg.sv
// Shared types and helpers for the HWPE stream burst scheduler.
package hwpe_stream_burst_scheduler_pkg;

  typedef enum logic {BSCHED_IDLE, BSCHED_BURST} bsched_state_t;

  // Width of each per-input accepted-beat counter.
  localparam int unsigned BSCHED_CNT_W = 32;

  // A zero length still moves one beat; oversized requests are clipped.
  function automatic int unsigned bsched_clip_len(input int unsigned len,
                                                  input int unsigned max_len);
    if (len == 0) begin
      return 1;
    end else if (len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal HWPE stream interface: valid/ready handshake with data and byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);

endinterface

// File: rtl/hwpe_stream_rr_pick.sv
// Combinational round-robin picker: first requester after 'last_i', wrapping.
module hwpe_stream_rr_pick #(
  parameter int unsigned NB_IN = 4,
  parameter int unsigned IDX_W = $clog2(NB_IN)
) (
  input  logic [NB_IN-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NB_IN-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             w_found;
  logic [IDX_W-1:0] w_j;

  // Scan last+1 .. last+NB_IN (mod NB_IN), keep the first hit.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int unsigned i = 1; i <= NB_IN; i++) begin
      w_j = IDX_W'((32'(last_i) + i) % NB_IN);
      if (!w_found && req_i[w_j]) begin
        w_found    = 1'b1;
        gnt_o[w_j] = 1'b1;
        idx_o      = w_j;
      end
    end
  end

endmodule

// File: rtl/hwpe_stream_burst_scheduler.sv
// Round-robin burst scheduler sharing one HWPE stream sink among NB_IN sources.
// A grant holds ownership for a whole burst so packets never interleave.
// Optional per-input beat counters: define HWPE_STREAM_BURST_SCHEDULER_PERF_EN.
module hwpe_stream_burst_scheduler
  import hwpe_stream_burst_scheduler_pkg::*;
#(
  parameter int unsigned NB_IN      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned BURST_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     clear_i,
  input  logic                                     enable_i,
  input  logic [NB_IN-1:0]                         req_mask_i,
  input  logic [BURST_W-1:0]                       burst_len_i,
  hwpe_stream_intf_stream.sink                     push_i [NB_IN-1:0],
  hwpe_stream_intf_stream.source                   pop_o,
  output logic [NB_IN-1:0]                         grant_o,
  output logic                                     busy_o,
  output logic                                     burst_done_o,
  output logic [NB_IN-1:0][BSCHED_CNT_W-1:0]       beat_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NB_IN);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  bsched_state_t      r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last;
  logic [BURST_W-1:0] r_len;
  logic [BURST_W-1:0] r_cnt;
  logic [NB_IN-1:0]   r_grant;
  logic               r_busy;

  logic [NB_IN-1:0]      w_valid;
  logic [DATA_WIDTH-1:0] w_data [NB_IN];
  logic [STRB_W-1:0]     w_strb [NB_IN];
  logic [NB_IN-1:0]      w_req;
  logic                  w_any;
  logic [NB_IN-1:0]      w_win_gnt;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_in_burst;
  logic                  w_pop_valid;
  logic                  w_beat;
  logic                  w_last_beat;

  // Flatten the interface array so the owner can be selected with a run-time index.
  for (genvar k = 0; k < NB_IN; k++) begin : g_in
    assign w_valid[k]      = push_i[k].valid;
    assign w_data[k]       = push_i[k].data;
    assign w_strb[k]       = push_i[k].strb;
    assign push_i[k].ready = w_in_burst && (r_owner == IDX_W'(k)) && pop_o.ready;
  end

  assign w_req = w_valid & req_mask_i;
  assign w_any = |w_req;

  hwpe_stream_rr_pick #(
    .NB_IN (NB_IN),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i  (w_req),
    .last_i (r_last),
    .gnt_o  (w_win_gnt),
    .idx_o  (w_win_idx)
  );

  assign w_in_burst  = (r_state == BSCHED_BURST);
  assign w_pop_valid = w_in_burst ? w_valid[r_owner] : 1'b0;
  assign pop_o.valid = w_pop_valid;
  assign pop_o.data  = w_in_burst ? w_data[r_owner] : '0;
  assign pop_o.strb  = w_in_burst ? w_strb[r_owner] : '0;

  assign w_beat       = w_pop_valid & pop_o.ready;
  assign w_last_beat  = w_beat && (r_cnt == (r_len - BURST_W'(1)));
  assign burst_done_o = w_last_beat;
  assign grant_o      = r_grant;
  assign busy_o       = r_busy;

  // Burst FSM: grant decision in IDLE, beat counting in BURST; clear wins over everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= BSCHED_IDLE;
      r_owner <= '0;
      r_last  <= IDX_W'(NB_IN - 1);
      r_len   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else if (clear_i) begin
      r_state <= BSCHED_IDLE;
      r_owner <= '0;
      r_last  <= IDX_W'(NB_IN - 1);
      r_len   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        BSCHED_IDLE: begin
          if (enable_i && w_any) begin
            r_state <= BSCHED_BURST;
            r_owner <= w_win_idx;
            r_last  <= w_win_idx;
            r_len   <= BURST_W'(bsched_clip_len(32'(burst_len_i), MAX_BURST));
            r_cnt   <= '0;
            r_grant <= w_win_gnt;
            r_busy  <= 1'b1;
          end
        end
        BSCHED_BURST: begin
          if (w_last_beat) begin
            r_state <= BSCHED_IDLE;
            r_cnt   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end else if (w_beat) begin
            r_cnt <= r_cnt + BURST_W'(1);
          end
        end
        default: r_state <= BSCHED_IDLE;
      endcase
    end
  end

`ifdef HWPE_STREAM_BURST_SCHEDULER_PERF_EN
  logic [NB_IN-1:0][BSCHED_CNT_W-1:0] r_beat_cnt;

  // Saturating count of beats accepted from each input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_beat_cnt <= '0;
    end else if (clear_i) begin
      r_beat_cnt <= '0;
    end else begin
      for (int k = 0; k < int'(NB_IN); k++) begin
        if (w_beat && (r_owner == IDX_W'(k)) && (r_beat_cnt[k] != '1)) begin
          r_beat_cnt[k] <= r_beat_cnt[k] + BSCHED_CNT_W'(1);
        end
      end
    end
  end

  assign beat_cnt_o = r_beat_cnt;
`else
  assign beat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_stream_burst_scheduler.sv
// Scoreboard bench for hwpe_stream_burst_scheduler: stimulus queues expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_hwpe_stream_burst_scheduler;

  localparam int NB = 4;
  localparam int BW = 5;

  typedef struct {
    int          owner;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        done;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_ni;
  logic              clear;
  logic              enable;
  logic [NB-1:0]     mask;
  logic [BW-1:0]     blen;
  logic              pop_ready;
  logic [NB-1:0]     s_valid;
  logic [31:0]       s_data [NB];
  logic [3:0]        s_strb [NB];
  logic [NB-1:0]     s_ready;
  logic [NB-1:0]     grant;
  logic              busy;
  logic              done;
  logic [NB-1:0][31:0] bcnt;
  logic [NB-1:0]     fire;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int src_seq [NB];
  int ex_seq [NB];
  int base;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push [NB-1:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop ();

  for (genvar k = 0; k < NB; k++) begin : g_src
    assign push[k].valid = s_valid[k];
    assign push[k].data  = s_data[k];
    assign push[k].strb  = s_strb[k];
    assign s_ready[k]    = push[k].ready;
  end
  assign pop.ready = pop_ready;

  hwpe_stream_burst_scheduler #(
    .NB_IN      (NB),
    .DATA_WIDTH (32),
    .MAX_BURST  (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clear_i      (clear),
    .enable_i     (enable),
    .req_mask_i   (mask),
    .burst_len_i  (blen),
    .push_i       (push),
    .pop_o        (pop),
    .grant_o      (grant),
    .busy_o       (busy),
    .burst_done_o (done),
    .beat_cnt_o   (bcnt)
  );

  function automatic logic [31:0] dat(input int k, input int s);
    return {8'(8'hA0 + k), 8'h5C, 16'(s * 3 + k)};
  endfunction

  function automatic logic [3:0] stb(input int k, input int s);
    return 4'(s + k + 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_burst(input int k, input int n, input int len, input int c0);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.owner = k;
      e.data  = dat(k, ex_seq[k]);
      e.strb  = stb(k, ex_seq[k]);
      e.done  = (j == len - 1);
      e.cyc   = (c0 < 0) ? -1 : c0 + j;
      q.push_back(e);
      ex_seq[k]++;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic wait_empty(input int max_cyc);
    for (int i = 0; i < max_cyc && q.size() != 0; i++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected beats never appeared", q.size());
      q.delete();
    end
    step(4);
  endtask

  // Source model: advance an input's sequence after each accepted beat.
  initial begin
    forever begin
      @(negedge clk);
      fire = s_valid & s_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < NB; k++) begin
        if (fire[k]) begin
          src_seq[k]++;
          s_data[k] = dat(k, src_seq[k]);
          s_strb[k] = stb(k, src_seq[k]);
        end
      end
    end
  end

  // Monitor: compare every accepted beat and check ready only reaches the expected owner.
  initial begin
    exp_t e;
    logic [3:0] eg;
    int own;
    forever begin
      @(negedge clk);
      if (rst_ni) begin
        own = (q.size() != 0) ? q[0].owner : -1;
        for (int k = 0; k < NB; k++) begin
          if (s_ready[k]) begin
            total++;
            if (own != k) begin
              bad++;
              $display("FAIL ready_owner: input %0d ready, expected owner %0d", k, own);
            end
          end
        end
        if (done && !(pop.valid && pop.ready)) begin
          total++;
          bad++;
          $display("FAIL done_no_beat: burst_done_o=1 without a beat at cyc %0d", cyc);
        end
        if (pop.valid && pop.ready) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: data=%h grant=%b cyc=%0d", pop.data, grant, cyc);
          end else begin
            e  = q.pop_front();
            eg = 4'b0001 << e.owner;
            if (pop.data !== e.data || pop.strb !== e.strb || done !== e.done ||
                grant !== eg || (e.cyc >= 0 && cyc != e.cyc)) begin
              bad++;
              $display("FAIL beat: got data=%h strb=%h done=%b grant=%b cyc=%0d want data=%h strb=%h done=%b grant=%b cyc=%0d",
                       pop.data, pop.strb, done, grant, cyc, e.data, e.strb, e.done, eg, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NB; k++) begin
      src_seq[k] = 0;
      ex_seq[k]  = 0;
      s_data[k]  = dat(k, 0);
      s_strb[k]  = stb(k, 0);
    end
    rst_ni = 1'b1; clear = 1'b0; enable = 1'b1; mask = 4'b1111; blen = 5'd4;
    pop_ready = 1'b1; s_valid = 4'b1111;
    #1 rst_ni = 1'b0;

    // 1: reset state with all inputs valid, then reset mid-burst
    repeat (3) @(negedge clk);
    chk("rst_pop_valid", 32'(pop.valid), 32'd0);
    chk("rst_pop_data", pop.data, 32'd0);
    chk("rst_pop_strb", 32'(pop.strb), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    for (int k = 0; k < NB; k++) chk("rst_beat_cnt", bcnt[k], 32'd0);
    step(1);
    base = cyc;
    push_burst(0, 2, 4, base + 1);
    rst_ni = 1'b1;
    step(3);
    pop_ready = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_pop_valid", 32'(pop.valid), 32'd0);
    step(1);
    rst_ni = 1'b1;
    pop_ready = 1'b1;
    base = cyc;
    push_burst(0, 4, 4, base + 1);
    step(1);
    enable = 1'b0;
    wait_empty(20);

    // 2: all valid, len 4 -> owners 0,1,2,3,0 with one idle cycle between bursts
    do_clear();
    base = cyc;
    for (int b = 0; b < 5; b++) push_burst(b % NB, 4, 4, base + 1 + 5 * b);
    enable = 1'b1;
    step(21);
    enable = 1'b0;
    wait_empty(40);

    // 3: only input 2 valid, len 3 -> three bursts to input 2
    s_valid = 4'b0100;
    blen = 5'd3;
    do_clear();
    base = cyc;
    for (int b = 0; b < 3; b++) push_burst(2, 3, 3, base + 1 + 4 * b);
    enable = 1'b1;
    step(9);
    enable = 1'b0;
    wait_empty(30);
`ifdef HWPE_STREAM_BURST_SCHEDULER_PERF_EN
    chk("perf_cnt0", bcnt[0], 32'd0);
    chk("perf_cnt1", bcnt[1], 32'd0);
    chk("perf_cnt2", bcnt[2], 32'd9);
    chk("perf_cnt3", bcnt[3], 32'd0);
`else
    for (int k = 0; k < NB; k++) chk("perf_tied0", bcnt[k], 32'd0);
`endif

    // 4: owner stalls 5 cycles, pop ready toggles; len/mask changes ignored mid-burst
    s_valid = 4'b1111;
    blen = 5'd8;
    do_clear();
    push_burst(0, 8, 8, -1);
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    blen = 5'd2;
    mask = 4'b1110;
    for (int i = 0; i < 40; i++) begin
      pop_ready = i[0];
      s_valid[0] = !(i >= 2 && i < 7);
      step(1);
    end
    pop_ready = 1'b1;
    s_valid = 4'b1111;
    mask = 4'b1111;
    wait_empty(30);

    // 5a: len 0 -> one-beat bursts
    blen = 5'd0;
    do_clear();
    base = cyc;
    for (int b = 0; b < 3; b++) push_burst(b, 1, 1, base + 1 + 2 * b);
    enable = 1'b1;
    step(5);
    enable = 1'b0;
    wait_empty(20);

    // 5b: len MAX_BURST+5 clipped to 16 beats; mask selects input 1 only
    blen = 5'd21;
    mask = 4'b0010;
    do_clear();
    base = cyc;
    push_burst(1, 16, 16, base + 1);
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    wait_empty(40);

    // 6: clear on beat 2 of 4 -> idle next cycle, arbitration restarts from input 0
    mask = 4'b0110;
    blen = 5'd4;
    do_clear();
    base = cyc;
    push_burst(1, 2, 4, base + 1);
    push_burst(1, 4, 4, base + 4);
    enable = 1'b1;
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);
    enable = 1'b0;
    wait_empty(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
